set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/cache_pkg.sv | 55 +++++
 rtl/cache_byte_lane.sv | 72 +++++++
 rtl/set_assoc_cache.sv | 270 +++++++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache: FSM states, load/store
// access types, byte-enable constants and the per-set replacement-state functions.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } cache_state_t;

    // Shared control typedef for the access type of a load or store.
    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_BYTE_U = 3'd1,
        MEM_HALF   = 3'd2,
        MEM_HALF_U = 3'd3,
        MEM_WORD   = 3'd4
    } mem_type_t;

    localparam int          OFFSET_WIDTH      = 2;
    localparam logic [1:0]  HALF_TOP_OFFSET   = 2'd3;
    localparam logic [1:0]  HALF_ALIAS_OFFSET = 2'd2;
    localparam logic [3:0]  BE_NONE           = 4'h0;
    localparam logic [3:0]  BE_BYTE           = 4'b0001;
    localparam logic [3:0]  BE_HALF           = 4'b0011;
    localparam logic [3:0]  BE_WORD           = 4'hF;

    // Replacement state: bit 0 alone for 2 ways; for 4 ways bit 0 picks the pair
    // (0 = evict from ways 0/1) and bits 1/2 pick inside the left/right pair.
    function automatic logic [1:0] lru_victim(input logic [2:0] lru, input int ways);
        case (ways)
            2:       return {1'b0, lru[0]};
            4:       return lru[0] ? {1'b1, lru[2]} : {1'b0, lru[1]};
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] lru_touch(input logic [2:0] lru, input logic [1:0] way, input int ways);
        logic [2:0] r;
        r = lru;
        case (ways)
            2: r[0] = ~way[0];
            4: begin
                r[0] = ~way[1];
                if (way[1]) r[2] = ~way[0];
                else        r[1] = ~way[0];
            end
            default: r = lru;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cache_byte_lane.sv
// Combinational byte-lane unit: load extraction with sign/zero extension, store
// lane positioning with byte enables, and merge of store bytes into a cached word.
module cache_byte_lane
    import cache_pkg::*;
(
    input  logic [31:0] word_in,
    input  mem_type_t   mem_type,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_be
);

    logic [1:0]  eff_off_s;
    logic [4:0]  shamt_s;
    logic [15:0] shifted_s;
    logic [31:0] mask_s;

    // Halfword at offset 3 aliases onto bytes 3:2.
    always_comb begin
        if (((mem_type == MEM_HALF) || (mem_type == MEM_HALF_U)) && (offset == HALF_TOP_OFFSET)) begin
            eff_off_s = HALF_ALIAS_OFFSET;
        end else begin
            eff_off_s = offset;
        end
        shamt_s   = {eff_off_s, 3'b000};
        shifted_s = 16'(word_in >> shamt_s);
    end

    // Per-type extraction and lane positioning.
    always_comb begin
        case (mem_type)
            MEM_BYTE: begin
                load_data  = {{24{shifted_s[7]}}, shifted_s[7:0]};
                lane_be    = BE_BYTE << eff_off_s;
                lane_wdata = {24'd0, store_data[7:0]} << shamt_s;
            end
            MEM_BYTE_U: begin
                load_data  = {24'd0, shifted_s[7:0]};
                lane_be    = BE_BYTE << eff_off_s;
                lane_wdata = {24'd0, store_data[7:0]} << shamt_s;
            end
            MEM_HALF: begin
                load_data  = {{16{shifted_s[15]}}, shifted_s};
                lane_be    = BE_HALF << eff_off_s;
                lane_wdata = {16'd0, store_data[15:0]} << shamt_s;
            end
            MEM_HALF_U: begin
                load_data  = {16'd0, shifted_s};
                lane_be    = BE_HALF << eff_off_s;
                lane_wdata = {16'd0, store_data[15:0]} << shamt_s;
            end
            default: begin
                load_data  = word_in;
                lane_be    = BE_WORD;
                lane_wdata = store_data;
            end
        endcase
    end

    // Expand byte enables into a bit mask and merge.
    always_comb begin
        mask_s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mask_s[8*i +: 8] = {8{lane_be[i]}};
        end
        merged_word = (word_in & ~mask_s) | (lane_wdata & mask_s);
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate set-associative cache with one word per line.
// Optional CACHE_STATS_EN adds saturating load hit/miss counters.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int WAYS        = 2
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iReq,
    output logic                  oReady,
    input  logic                  iWriteEn,
    input  mem_type_t             iMemoryInstructionType,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic [DATA_WIDTH-1:0] iMemData,
    output logic                  oRespValid,
    output logic [DATA_WIDTH-1:0] oMemData,
    input  logic                  iFlush,
    output logic                  oMemReq,
    output logic                  oMemWe,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0] oMemWData,
    output logic [3:0]            oMemBe,
    input  logic                  iMemAck,
    input  logic [DATA_WIDTH-1:0] iMemRData,
    output logic [15:0]           oHitCount,
    output logic [15:0]           oMissCount
);

    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    cache_state_t            state_r, state_nxt_s;
    logic                    req_we_r;
    mem_type_t               req_type_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic [DATA_WIDTH-1:0]   req_wdata_r;

    logic [DATA_WIDTH-1:0]   data_r  [WAYS][SETS];
    logic [TAG_W-1:0]        tag_r   [WAYS][SETS];
    logic [SETS-1:0]         valid_r [WAYS];
    logic [2:0]              lru_r   [SETS];

    logic [INDEX_WIDTH-1:0]  idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic [ADDR_WIDTH-1:0]   line_addr_s;
    logic                    accept_s, hit_s, inv_found_s;
    logic [1:0]              hit_way_s, inv_way_s, victim_s;
    logic [DATA_WIDTH-1:0]   hit_word_s, lane_word_s;
    logic [31:0]             lane_load_s, lane_merged_s, lane_wdata_s;
    logic [3:0]              lane_be_s;

    logic                    mem_req_r, mem_we_r, resp_valid_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_data_r;
    logic [3:0]              mem_be_r;
    logic                    mem_req_nxt_s, mem_we_nxt_s, resp_valid_nxt_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_nxt_s, mem_data_nxt_s;
    logic [3:0]              mem_be_nxt_s;

    assign oReady      = (state_r == ST_IDLE) && !iFlush;
    assign accept_s    = iReq && oReady;
    assign idx_s       = req_addr_r[INDEX_WIDTH+1:2];
    assign tag_s       = req_addr_r[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign line_addr_s = {req_addr_r[ADDR_WIDTH-1:2], 2'b00};
    assign lane_word_s = (state_r == ST_REFILL) ? iMemRData : hit_word_s;

    cache_byte_lane u_lane (
        .word_in     (lane_word_s),
        .mem_type    (req_type_r),
        .offset      (req_addr_r[1:0]),
        .store_data  (req_wdata_r),
        .load_data   (lane_load_s),
        .merged_word (lane_merged_s),
        .lane_wdata  (lane_wdata_s),
        .lane_be     (lane_be_s)
    );

    // Tag compare and victim choice: lowest invalid way first, else the LRU way.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = 2'd0;
        hit_word_s  = {DATA_WIDTH{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_r[w][idx_s] && (tag_r[w][idx_s] == tag_s)) begin
                hit_s      = 1'b1;
                hit_way_s  = 2'(w);
                hit_word_s = data_r[w][idx_s];
            end else begin
                hit_s = hit_s;
            end
            if (!inv_found_s && !valid_r[w][idx_s]) begin
                inv_found_s = 1'b1;
                inv_way_s   = 2'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        victim_s = inv_found_s ? inv_way_s : lru_victim(lru_r[idx_s], WAYS);
    end

    // State register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = accept_s ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: begin
                if (req_we_r)   state_nxt_s = ST_WRITE;
                else if (hit_s) state_nxt_s = ST_RESP;
                else            state_nxt_s = ST_REFILL;
            end
            ST_REFILL: state_nxt_s = iMemAck ? ST_RESP : ST_REFILL;
            ST_WRITE:  state_nxt_s = iMemAck ? ST_RESP : ST_WRITE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        mem_req_nxt_s    = mem_req_r;
        mem_we_nxt_s     = mem_we_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        mem_be_nxt_s     = mem_be_r;
        mem_data_nxt_s   = mem_data_r;
        resp_valid_nxt_s = (state_nxt_s == ST_RESP);
        case (state_r)
            ST_LOOKUP: begin
                if (req_we_r) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b1;
                    mem_addr_nxt_s  = line_addr_s;
                    mem_wdata_nxt_s = lane_wdata_s;
                    mem_be_nxt_s    = lane_be_s;
                end else if (hit_s) begin
                    mem_data_nxt_s  = lane_load_s;
                end else begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = line_addr_s;
                    mem_be_nxt_s    = BE_WORD;
                end
            end
            ST_REFILL: begin
                if (iMemAck) begin
                    mem_req_nxt_s  = 1'b0;
                    mem_data_nxt_s = lane_load_s;
                end else begin
                    mem_req_nxt_s  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (iMemAck) begin
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            default: mem_req_nxt_s = mem_req_r;
        endcase
    end

    // Output registers; async reset drops an in-flight memory request at once.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            mem_be_r     <= BE_NONE;
            mem_data_r   <= {DATA_WIDTH{1'b0}};
            resp_valid_r <= 1'b0;
        end else begin
            mem_req_r    <= mem_req_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            mem_be_r     <= mem_be_nxt_s;
            mem_data_r   <= mem_data_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
        end
    end

    assign oMemReq    = mem_req_r;
    assign oMemWe     = mem_we_r;
    assign oMemAddr   = mem_addr_r;
    assign oMemWData  = mem_wdata_r;
    assign oMemBe     = mem_be_r;
    assign oMemData   = mem_data_r;
    assign oRespValid = resp_valid_r;

    // Request capture on accept; inputs are ignored until the next accept.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            req_we_r    <= 1'b0;
            req_type_r  <= MEM_WORD;
            req_addr_r  <= {ADDR_WIDTH{1'b0}};
            req_wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            req_we_r    <= iWriteEn;
            req_type_r  <= iMemoryInstructionType;
            req_addr_r  <= iAddress;
            req_wdata_r <= iMemData;
        end
    end

    // Valid and replacement state: flush, MRU update on hit, install on refill.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= {SETS{1'b0}};
            for (int s = 0; s < SETS; s++) lru_r[s] <= 3'd0;
        end else if ((state_r == ST_IDLE) && iFlush) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= {SETS{1'b0}};
        end else if ((state_r == ST_LOOKUP) && hit_s) begin
            lru_r[idx_s] <= lru_touch(lru_r[idx_s], hit_way_s, WAYS);
        end else if ((state_r == ST_REFILL) && iMemAck) begin
            for (int w = 0; w < WAYS; w++) begin
                if (victim_s == 2'(w)) valid_r[w][idx_s] <= 1'b1;
            end
            lru_r[idx_s] <= lru_touch(lru_r[idx_s], victim_s, WAYS);
        end
    end

    // Data/tag arrays: store-hit merge during LOOKUP, refill install on ack.
    always_ff @(posedge iClk) begin
        for (int w = 0; w < WAYS; w++) begin
            if ((state_r == ST_LOOKUP) && req_we_r && hit_s && (hit_way_s == 2'(w))) begin
                data_r[w][idx_s] <= lane_merged_s;
            end else if ((state_r == ST_REFILL) && iMemAck && (victim_s == 2'(w))) begin
                data_r[w][idx_s] <= iMemRData;
                tag_r[w][idx_s]  <= tag_s;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_r, miss_count_r;

    // Saturating load hit/miss counters, sampled in LOOKUP.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            hit_count_r  <= 16'd0;
            miss_count_r <= 16'd0;
        end else if ((state_r == ST_LOOKUP) && !req_we_r) begin
            if (hit_s && (hit_count_r != 16'hFFFF))        hit_count_r  <= hit_count_r + 16'd1;
            else if (!hit_s && (miss_count_r != 16'hFFFF)) miss_count_r <= miss_count_r + 16'd1;
        end
    end

    assign oHitCount  = hit_count_r;
    assign oMissCount = miss_count_r;
`else
    assign oHitCount  = 16'd0;
    assign oMissCount = 16'd0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache (WAYS=2): expected responses are
// queued when a request is driven and compared when oRespValid pulses.
module tb_set_assoc_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    mem_type_t   mtype = MEM_WORD;
    logic [31:0] addr = 32'd0, wdata = 32'd0, mem_rdata = 32'd0;
    logic        ready, resp_valid, mem_req, mem_we;
    logic [31:0] resp_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [15:0] hit_cnt, miss_cnt;

    int          errors = 0;
    int          checks = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] exp_q[$];

    set_assoc_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_WIDTH(4), .WAYS(2)) dut (
        .iClk(clk), .iRstN(rst_n), .iReq(req), .oReady(ready), .iWriteEn(we),
        .iMemoryInstructionType(mtype), .iAddress(addr), .iMemData(wdata),
        .oRespValid(resp_valid), .oMemData(resp_data), .iFlush(flush),
        .oMemReq(mem_req), .oMemWe(mem_we), .oMemAddr(mem_addr), .oMemWData(mem_wdata),
        .oMemBe(mem_be), .iMemAck(mem_ack), .iMemRData(mem_rdata),
        .oHitCount(hit_cnt), .oMissCount(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction with a memory responder that acks two cycles after oMemReq rises.
    task automatic do_req(input string tag, input logic w, input mem_type_t ty, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input logic exp_mem,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_resp);
        int          n_req, wait_c, lat;
        logic        got, prev;
        logic [31:0] s_addr, s_wd, obs;
        logic [3:0]  s_be;
        logic        s_we;
        exp_q.push_back(exp_resp);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; mtype = ty; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
        n_req = 0; wait_c = 0; got = 1'b0; prev = 1'b0; lat = 0; obs = 32'd0;
        s_addr = 32'd0; s_wd = 32'd0; s_be = 4'd0; s_we = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !prev) begin
                n_req++;
                s_addr = mem_addr; s_wd = mem_wdata; s_be = mem_be; s_we = mem_we;
            end
            if (mem_req) begin
                wait_c++;
                if (wait_c == 2) begin mem_ack = 1'b1; mem_rdata = rd; end
            end
            prev = mem_req;
            if (resp_valid) begin got = 1'b1; lat = k; obs = resp_data; end
        end
        mem_ack = 1'b0;
        chk({tag, "_resp_seen"}, 32'(got), 32'd1);
        if (got) chk({tag, "_data"}, obs, exp_q.pop_front());
        else     void'(exp_q.pop_front());
        chk({tag, "_memreqs"}, 32'(n_req), 32'(exp_mem));
        if (exp_mem) begin
            chk({tag, "_mem_we"}, 32'(s_we), 32'(w));
            chk({tag, "_mem_addr"}, s_addr, {a[31:2], 2'b00});
            chk({tag, "_mem_be"}, 32'(s_be), 32'(exp_be));
            if (w) chk({tag, "_mem_wdata"}, s_wd, exp_wd);
        end else begin
            chk({tag, "_hit_latency"}, 32'(lat), 32'd2);
        end
    endtask

    task automatic ld(input string tag, input mem_type_t ty, input logic [31:0] a,
                      input logic [31:0] rd, input logic exp_mem, input logic [31:0] exp);
        do_req(tag, 1'b0, ty, a, 32'd0, rd, exp_mem, BE_WORD, 32'd0, exp);
        last_data = exp;
        if (exp_mem) exp_misses++;
        else         exp_hits++;
    endtask

    task automatic st(input string tag, input mem_type_t ty, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_wd);
        do_req(tag, 1'b1, ty, a, wd, 32'h0BAD_0BAD, 1'b1, be, exp_wd, last_data);
    endtask

    initial begin
        int  n;
        logic got;
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_data", resp_data, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        ld("cold_lw", MEM_WORD, 32'h0001_0040, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        ld("hit_lw", MEM_WORD, 32'h0001_0040, 32'hBAD0_BAD0, 1'b0, 32'hDEAD_BEEF);
        ld("lb_off3", MEM_BYTE, 32'h0000_0107, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80);
        ld("lbu_off3", MEM_BYTE_U, 32'h0000_0107, 32'hBAD0_BAD0, 1'b0, 32'h0000_0080);
        ld("lh_off3", MEM_HALF, 32'h0000_0107, 32'hBAD0_BAD0, 1'b0, 32'hFFFF_80FF);
        ld("lhu_off1", MEM_HALF_U, 32'h0000_0105, 32'hBAD0_BAD0, 1'b0, 32'h0000_FF00);
        ld("lb_off2", MEM_BYTE, 32'h0000_0106, 32'hBAD0_BAD0, 1'b0, 32'hFFFF_FFFF);

        st("sh_off2", MEM_HALF, 32'h0001_0042, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000);
        ld("lw_after_sh", MEM_WORD, 32'h0001_0040, 32'hBAD0_BAD0, 1'b0, 32'hABCD_BEEF);
        st("sb_off1", MEM_BYTE, 32'h0001_0041, 32'h1234_5677, 4'b0010, 32'h0000_7700);
        ld("lw_after_sb", MEM_WORD, 32'h0001_0040, 32'hBAD0_BAD0, 1'b0, 32'hABCD_77EF);
        st("sh_off3", MEM_HALF_U, 32'h0001_0043, 32'h0000_5566, 4'b1100, 32'h5566_0000);
        ld("lw_after_sh3", MEM_WORD, 32'h0001_0040, 32'hBAD0_BAD0, 1'b0, 32'h5566_77EF);
        st("sw_off3", MEM_WORD, 32'h0001_0043, 32'h1122_3344, 4'hF, 32'h1122_3344);
        ld("lw_after_sw", MEM_WORD, 32'h0001_0040, 32'hBAD0_BAD0, 1'b0, 32'h1122_3344);
        st("sw_miss", MEM_WORD, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
        ld("lw_no_alloc", MEM_WORD, 32'h0000_0300, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA);

        // Same set: A, B, A, C -> C replaces B (least recently used).
        ld("lru_a", MEM_WORD, 32'h0000_0008, 32'hAAAA_0001, 1'b1, 32'hAAAA_0001);
        ld("lru_b", MEM_WORD, 32'h0000_1008, 32'hBBBB_0002, 1'b1, 32'hBBBB_0002);
        ld("lru_a_hit", MEM_WORD, 32'h0000_0008, 32'hBAD0_BAD0, 1'b0, 32'hAAAA_0001);
        ld("lru_c", MEM_WORD, 32'h0000_2008, 32'hCCCC_0003, 1'b1, 32'hCCCC_0003);
        ld("lru_a_kept", MEM_WORD, 32'h0000_0008, 32'hBAD0_BAD0, 1'b0, 32'hAAAA_0001);
        ld("lru_b_evicted", MEM_WORD, 32'h0000_1008, 32'hBBBB_0002, 1'b1, 32'hBBBB_0002);

        // Flush together with a request: no accept, cached lines invalidated.
        @(negedge clk);
        req = 1'b1; flush = 1'b1; we = 1'b0; mtype = MEM_WORD; addr = 32'h0001_0040;
        #1 chk("flush_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_no_resp", 32'(resp_valid), 32'd0);
        chk("flush_no_memreq", 32'(mem_req), 32'd0);
        ld("flush_miss", MEM_WORD, 32'h0001_0040, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D);

        // Reset while a refill request is outstanding.
        @(negedge clk);
        req = 1'b1; we = 1'b0; mtype = MEM_WORD; addr = 32'h0000_0010;
        @(posedge clk); #1 req = 1'b0;
        got = 1'b0;
        for (n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = mem_req;
        end
        chk("rst_refill_req_seen", 32'(got), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_memreq", 32'(mem_req), 32'd0);
        chk("midrst_mem_be", 32'(mem_be), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_data", resp_data, 32'd0);
        exp_q.delete();
        last_data = 32'd0; exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1212_1212;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_no_resp", 32'(resp_valid), 32'd0);
        chk("late_ack_no_memreq", 32'(mem_req), 32'd0);
        chk("late_ack_ready", 32'(ready), 32'd1);
        ld("post_rst_miss", MEM_WORD, 32'h0001_0040, 32'h600D_CAFE, 1'b1, 32'h600D_CAFE);
        ld("post_rst_hit", MEM_WORD, 32'h0001_0040, 32'hBAD0_BAD0, 1'b0, 32'h600D_CAFE);

`ifdef CACHE_STATS_EN
        chk("stats_hits", 32'(hit_cnt), 32'(exp_hits));
        chk("stats_misses", 32'(miss_cnt), 32'(exp_misses));
`else
        chk("stats_hits_zero", 32'(hit_cnt), 32'd0);
        chk("stats_misses_zero", 32'(miss_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
